aes128_core_arbiter: RTL and testbench
======================================

Name: aes128_core_arbiter

Overview:
Shares one AES-128 encryption core between NUM_REQ requesters. Each requester presents a key and plaintext over a valid/ready handshake. The block grants requesters round-robin, pulses the core's load input, and waits a fixed core latency. It then returns the ciphertext tagged with the requester ID over a valid/ready response channel. Only one job is in flight at a time. The block sits between the request sources and the core, which has a load_plain_text / key / plain_text / cipher_text interface.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
CORE_LATENCY, 11, cycles from the core_load cycle (index 0) to the cycle in which core_ct is valid (index CORE_LATENCY); minimum 1
ID_W, 2, requester ID width, must equal clog2(NUM_REQ)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_key  in  NUM_REQ*128  key of requester i in bits [128*i +: 128]
req_pt  in  NUM_REQ*128  plaintext of requester i, same packing
core_load  out  1  one-cycle load pulse to the core
core_key  out  128  key to the core, held stable from the LOAD cycle through WAIT
core_pt  out  128  plaintext to the core, held stable from the LOAD cycle through WAIT
core_ct  in  128  ciphertext from the core
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  ID of the requester that owns the response
rsp_ct  out  128  captured ciphertext
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at a rising edge):
  - state <= IDLE; all outputs 0, including core_key, core_pt, rsp_ct and rsp_id.
  - The round-robin pointer is set to last_grant = NUM_REQ-1, so requester 0 has top priority.
- Reset has priority over everything. Asserting rst mid-job abandons the job: no response is produced and no req_ready is issued in that cycle.
- IDLE:
  - The winner g is the first i with req_valid[i]=1, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - req_ready[g]=1 combinationally in the same cycle; a transfer occurs when req_valid[g] & req_ready[g].
  - On transfer: capture req_key[g] and req_pt[g] into core_key and core_pt; capture g into the ID register; next state LOAD.
  - No valid requests: stay in IDLE with req_ready=0.
- LOAD:
  - core_load=1 for exactly this one cycle.
  - Latency counter <= CORE_LATENCY; next state WAIT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle where the counter equals 1, which is cycle index CORE_LATENCY counted from LOAD: rsp_ct <= core_ct and rsp_id <= ID; next state RESP.
- RESP:
  - rsp_valid=1; rsp_ct and rsp_id are held stable until rsp_ready=1.
  - On handshake: last_grant <= ID; next state IDLE, where rsp_valid=0.
- req_ready=0 in every state except IDLE. New requests are never accepted while busy, including in the RESP handshake cycle.
- Throughput: back-to-back jobs complete every CORE_LATENCY+3 cycles (IDLE, LOAD, CORE_LATENCY WAIT cycles, RESP).
- A requester may drop req_valid before it is granted; no penalty applies and the pointer does not change.
- The pointer updates only on a completed response handshake.

Decomposition:
- Package aes128_pkg holds:
  - localparam AES_BLK_W = 128;
  - the state encoding (IDLE=2'd0, LOAD=2'd1, WAIT=2'd2, RESP=2'd3);
  - a clog2 function for ID_W checks.
- Sub-module aes128_rr_arbiter is combinational. Inputs: req_valid, last_grant. Outputs: one-hot grant, grant index, any_valid.
- The top module holds the FSM, the latency counter and the data registers.

Test Plan:
- Bench setup: a stub core returns key XOR pt registered CORE_LATENCY cycles after core_load, with CORE_LATENCY=11.
- Single request: requester 0 with key=100F0E0D0C0B0A090807060504030201 and pt=54494d47206e616c6f4e20726f6e6f43, accepted in cycle G -> core_load high only in G+1; rsp_valid in G+13; rsp_id=0; rsp_ct=key^pt.
- All four requesters valid from reset, rsp_ready=1 -> grants in order 0,1,2,3,0; consecutive grants 14 cycles apart; each rsp_id matches its key^pt.
- Wrap-around: last_grant=3, req_valid=4'b1010 -> requester 1 granted; next grant is 3.
- Backpressure: rsp_ready=0 for 20 cycles while in RESP -> rsp_valid, rsp_ct and rsp_id stable; req_ready=0; busy=1; handshake on cycle 21 then IDLE.
- Reset in WAIT (5 cycles after core_load) -> next cycle all outputs 0, busy=0, no response for the aborted job; a fresh request from requester 2 is then served normally with requester 0 priority restored.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared constants, FSM encoding and helpers for the AES-128 core arbiter.
package aes128_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/aes128_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after last_grant, with wrap-around.
module aes128_rr_arbiter
    import aes128_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               any_valid_o
);

    int idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_valid_o = 1'b0;
        idx         = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant_i) + off) % NUM_REQ;
            if (!any_valid_o && req_valid_i[idx]) begin
                any_valid_o  = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/aes128_core_arbiter.sv
// Shares one AES-128 core among NUM_REQ requesters; one job in flight, round-robin grant,
// fixed core latency, ciphertext returned tagged with the owner ID.
module aes128_core_arbiter
    import aes128_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CORE_LATENCY = 11,
    parameter int ID_W         = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   req_key,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   req_pt,
    output logic                           core_load,
    output logic [AES_BLK_W-1:0]           core_key,
    output logic [AES_BLK_W-1:0]           core_pt,
    input  logic [AES_BLK_W-1:0]           core_ct,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [AES_BLK_W-1:0]           rsp_ct,
    output logic                           busy
);

    localparam int CNT_W = clog2(CORE_LATENCY + 1);

    if (ID_W != clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [AES_BLK_W-1:0] key_q, key_d;
    logic [AES_BLK_W-1:0] pt_q, pt_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [AES_BLK_W-1:0] rsp_ct_q, rsp_ct_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]      last_q, last_d;

    logic [NUM_REQ-1:0]   grant_oh;
    logic [ID_W-1:0]      grant_idx;
    logic                 any_valid;
    logic [AES_BLK_W-1:0] key_sel;
    logic [AES_BLK_W-1:0] pt_sel;

    aes128_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_valid_i  (req_valid),
        .last_grant_i (last_q),
        .grant_o      (grant_oh),
        .grant_idx_o  (grant_idx),
        .any_valid_o  (any_valid)
    );

    // One-hot mux of the winning requester's key and plaintext.
    always_comb begin
        key_sel = '0;
        pt_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                key_sel = req_key[i*AES_BLK_W +: AES_BLK_W];
                pt_sel  = req_pt[i*AES_BLK_W +: AES_BLK_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            key_q    <= '0;
            pt_q     <= '0;
            id_q     <= '0;
            rsp_ct_q <= '0;
            rsp_id_q <= '0;
            last_q   <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            pt_q     <= pt_d;
            id_q     <= id_d;
            rsp_ct_q <= rsp_ct_d;
            rsp_id_q <= rsp_id_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        pt_d      = pt_q;
        id_d      = id_q;
        rsp_ct_d  = rsp_ct_q;
        rsp_id_d  = rsp_id_q;
        last_d    = last_q;
        req_ready = '0;
        core_load = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The winner is always a valid requester, so granting it is a transfer.
                if (any_valid && !rst) begin
                    req_ready = grant_oh;
                    key_d     = key_sel;
                    pt_d      = pt_sel;
                    id_d      = grant_idx;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                core_load = 1'b1;
                cnt_d     = CNT_W'(CORE_LATENCY);
                state_d   = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    rsp_ct_d = core_ct;
                    rsp_id_d = id_q;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    last_d  = rsp_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_key = key_q;
    assign core_pt  = pt_q;
    assign rsp_ct   = rsp_ct_q;
    assign rsp_id   = rsp_id_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_aes128_core_arbiter.sv
// Directed bench for aes128_core_arbiter with a stub core (ct = key ^ pt after CORE_LATENCY).
module tb_aes128_core_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int CORE_LATENCY = 11;
    localparam int ID_W         = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_key;
    logic [NUM_REQ*128-1:0] req_pt;
    logic                   core_load;
    logic [127:0]           core_key;
    logic [127:0]           core_pt;
    logic [127:0]           core_ct = '0;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [ID_W-1:0]        rsp_id;
    logic [127:0]           rsp_ct;
    logic                   busy;

    logic [127:0] key_a [NUM_REQ];
    logic [127:0] pt_a  [NUM_REQ];

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [127:0]    ct;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   grant_id_q[$];
    int   grant_cyc_q[$];
    int   cyc = 0;
    int   load_cnt = 0;
    int   rsp_seen = 0;
    int   stub_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    aes128_core_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .CORE_LATENCY (CORE_LATENCY),
        .ID_W         (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_key   (req_key),
        .req_pt    (req_pt),
        .core_load (core_load),
        .core_key  (core_key),
        .core_pt   (core_pt),
        .core_ct   (core_ct),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_ct    (rsp_ct),
        .busy      (busy)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_key[i*128 +: 128] = key_a[i];
            req_pt[i*128 +: 128]  = pt_a[i];
        end
    end

    // Stub core: garbage until index CORE_LATENCY after the load cycle, then key ^ pt.
    always @(posedge clk) begin
        if (core_load) begin
            stub_cnt <= CORE_LATENCY;
            core_ct  <= {$urandom, $urandom, $urandom, $urandom};
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 2) core_ct <= core_key ^ core_pt;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on request transfer, pop and compare on response handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (core_load) load_cnt++;
            if (rsp_valid) rsp_seen++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back('{id: ID_W'(i), ct: key_a[i] ^ pt_a[i]});
                    grant_id_q.push_back(i);
                    grant_cyc_q.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 128'(exp_q.size()), 128'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_rsp_id", 128'(rsp_id), 128'(mon_e.id));
                    chk("sb_rsp_ct", rsp_ct, mon_e.ct);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        chk(tag, 128'(rsp_valid), 128'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick(1);
            n++;
        end
        chk(tag, 128'(busy), 128'd0);
    endtask

    task automatic wait_grants(input string tag, input int target);
        int n;
        n = 0;
        while (grant_id_q.size() < target && n < 400) begin
            tick(1);
            n++;
        end
        chk(tag, 128'(grant_id_q.size()), 128'(target));
    endtask

    task automatic chk_grant(input string tag, input int k, input int exp_id);
        chk(tag, 128'((k < grant_id_q.size()) ? grant_id_q[k] : -1), 128'(exp_id));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_req_ready"}, 128'(req_ready), 128'd0);
        chk({tag, "_core_load"}, 128'(core_load), 128'd0);
        chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_core_key"}, core_key, 128'd0);
        chk({tag, "_core_pt"}, core_pt, 128'd0);
        chk({tag, "_rsp_ct"}, rsp_ct, 128'd0);
        chk({tag, "_rsp_id"}, 128'(rsp_id), 128'd0);
    endtask

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           g_cyc;
        int           l0;
        int           r0;
        int           n;
        int           exp_ids[5];
        logic [127:0] exp_ct;

        for (int i = 0; i < NUM_REQ; i++) begin
            key_a[i] = '0;
            pt_a[i]  = '0;
        end

        // Reset state
        rst = 1'b1;
        tick(2);
        chk_idle_zero("reset");
        rst = 1'b0;

        // Single request from requester 0, latency check
        key_a[0]  = 128'h100F0E0D0C0B0A090807060504030201;
        pt_a[0]   = 128'h54494d47206e616c6f4e20726f6e6f43;
        l0        = load_cnt;
        req_valid = 4'b0001;
        #1;
        chk("single_req_ready", 128'(req_ready), 128'h1);
        g_cyc = cyc;
        tick(1);
        req_valid = '0;
        chk("single_load_g1", 128'(core_load), 128'd1);
        chk("single_core_key", core_key, key_a[0]);
        chk("single_core_pt", core_pt, pt_a[0]);
        tick(1);
        chk("single_load_g2", 128'(core_load), 128'd0);
        chk("single_busy", 128'(busy), 128'd1);
        wait_rsp("single_rsp_timeout");
        chk("single_rsp_latency", 128'(cyc - g_cyc), 128'd13);
        chk("single_rsp_id", 128'(rsp_id), 128'd0);
        chk("single_rsp_ct", rsp_ct, key_a[0] ^ pt_a[0]);
        rsp_ready = 1'b1;
        tick(1);
        chk("single_idle_busy", 128'(busy), 128'd0);
        chk("single_idle_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("single_load_count", 128'(load_cnt - l0), 128'd1);

        // All four valid from reset: 0,1,2,3,0 at 14-cycle spacing
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        grant_id_q.delete();
        grant_cyc_q.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            key_a[i] = {$urandom, $urandom, $urandom, $urandom};
            pt_a[i]  = {$urandom, $urandom, $urandom, $urandom};
        end
        req_valid = 4'b1111;
        wait_grants("rr_grants_timeout", 5);
        req_valid = '0;
        exp_ids = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            chk_grant($sformatf("rr_grant_%0d", k), k, exp_ids[k]);
        end
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("rr_gap_%0d", k),
                128'((k < grant_cyc_q.size()) ? grant_cyc_q[k] - grant_cyc_q[k-1] : -1), 128'd14);
        end
        wait_idle("rr_drain");
        chk("rr_queue_empty", 128'(exp_q.size()), 128'd0);

        // Wrap-around: make last_grant 3, then offer 1010
        grant_id_q.delete();
        req_valid = 4'b1000;
        wait_grants("wrap_pre_timeout", 1);
        req_valid = '0;
        wait_idle("wrap_pre_drain");
        chk_grant("wrap_pre_grant", 0, 3);
        grant_id_q.delete();
        req_valid = 4'b1010;
        wait_grants("wrap_timeout", 2);
        req_valid = '0;
        wait_idle("wrap_drain");
        chk_grant("wrap_first", 0, 1);
        chk_grant("wrap_second", 1, 3);

        // Backpressure on requester 2 with other requesters asking
        rsp_ready = 1'b0;
        key_a[2] = {$urandom, $urandom, $urandom, $urandom};
        pt_a[2]  = {$urandom, $urandom, $urandom, $urandom};
        exp_ct   = key_a[2] ^ pt_a[2];
        grant_id_q.delete();
        req_valid = 4'b0100;
        wait_grants("bp_grant_timeout", 1);
        req_valid = 4'b1111;
        wait_rsp("bp_rsp_timeout");
        for (int k = 0; k < 20; k++) begin
            chk("bp_rsp_valid", 128'(rsp_valid), 128'd1);
            chk("bp_rsp_ct", rsp_ct, exp_ct);
            chk("bp_rsp_id", 128'(rsp_id), 128'd2);
            chk("bp_req_ready", 128'(req_ready), 128'd0);
            chk("bp_busy", 128'(busy), 128'd1);
            tick(1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_req_ready", 128'(req_ready), 128'd0);
        chk("bp_hs_rsp_valid", 128'(rsp_valid), 128'd1);
        tick(1);
        req_valid = '0;
        chk("bp_after_busy", 128'(busy), 128'd0);
        chk("bp_after_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("bp_grant_count", 128'(grant_id_q.size()), 128'd1);

        // Move pointer to 0, then abort a job from requester 1 in WAIT
        grant_id_q.delete();
        req_valid = 4'b0001;
        wait_grants("abort_pre_timeout", 1);
        req_valid = '0;
        wait_idle("abort_pre_drain");
        key_a[1] = {$urandom, $urandom, $urandom, $urandom};
        pt_a[1]  = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b0010;
        n = 0;
        while (core_load !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        req_valid = '0;
        chk("abort_load_seen", 128'(core_load), 128'd1);
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_idle_zero("abort");
        r0 = rsp_seen;
        tick(20);
        chk("abort_no_rsp", 128'(rsp_seen - r0), 128'd0);
        chk("abort_queue_empty", 128'(exp_q.size()), 128'd0);

        // Requester 0 priority restored; requester 2 served next
        grant_id_q.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            key_a[i] = {$urandom, $urandom, $urandom, $urandom};
            pt_a[i]  = {$urandom, $urandom, $urandom, $urandom};
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0101;
        wait_grants("post_abort_timeout", 2);
        req_valid = '0;
        wait_idle("post_abort_drain");
        chk_grant("post_abort_first", 0, 0);
        chk_grant("post_abort_second", 1, 2);
        chk("final_queue_empty", 128'(exp_q.size()), 128'd0);

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
